note_plot_scheduler: RTL



---
 rtl/music_pkg.sv | 16 +
 rtl/pixel_sweeper.sv | 50 +++++
 rtl/note_plot_scheduler.sv | 136 +++++++++++++
 3 files changed

// File: rtl/music_pkg.sv
// Shared constants and FSM state type for the piano-roll plotting path.
package music_pkg;

    localparam int SCREEN_W         = 160;
    localparam int SCREEN_H         = 120;
    localparam int NOTES_PER_OCTAVE = 12;

    localparam logic [2:0] BLACK = 3'b000;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        DRAW
    } state_t;

endpackage

// File: rtl/pixel_sweeper.sv
// 2D raster counter: walks x0..x0+w-1 (inner) by y0..y0+h-1 (outer), one pixel per cycle.
module pixel_sweeper (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] x0,
    input  logic [6:0] y0,
    input  logic [7:0] w,
    input  logic [6:0] h,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic       active,
    output logic       last
);

    logic [7:0] x_first;
    logic [7:0] x_last;
    logic [6:0] y_last;

    assign last = active && (x == x_last) && (y == y_last);

    // x and y hold the final pixel once the sweep ends so the plot port stays stable.
    always_ff @(posedge clk) begin
        if (reset) begin
            x       <= '0;
            y       <= '0;
            x_first <= '0;
            x_last  <= '0;
            y_last  <= '0;
            active  <= 1'b0;
        end else if (start) begin
            x       <= x0;
            y       <= y0;
            x_first <= x0;
            x_last  <= x0 + w - 8'd1;
            y_last  <= y0 + h - 7'd1;
            active  <= 1'b1;
        end else if (active) begin
            if (last) begin
                active <= 1'b0;
            end else if (x == x_last) begin
                x <= x_first;
                y <= y + 7'd1;
            end else begin
                x <= x + 8'd1;
            end
        end
    end

endmodule

// File: rtl/note_plot_scheduler.sv
// Arbitrates the VGA plot port between note-draw blocks on a scrolling piano-roll and full-screen clears.
module note_plot_scheduler
    import music_pkg::*;
#(
    parameter int BOX_W    = 4,
    parameter int BOX_H    = 2,
    parameter int X_START  = 4,
    parameter int COL_STEP = 6,
    parameter int Y_BASE   = 110
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       draw_req,
    input  logic [3:0] note,
    input  logic [1:0] octave,
    input  logic       clear_req,
    output logic       draw_ack,
    output logic       bad_note,
    output logic       busy,
    output logic       done,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       writeEn
);

    state_t     state;
    logic [7:0] cursor;
    logic       slot_full;
    logic [3:0] slot_note;
    logic [1:0] slot_octave;
    logic       clear_pending;

    logic [5:0] idx;
    logic [6:0] draw_y0;
    logic [2:0] draw_colour;
    logic       wrap;

    logic       start_clear;
    logic       start_draw;
    logic       sweep_start;
    logic [7:0] sweep_x0;
    logic [6:0] sweep_y0;
    logic [7:0] sweep_w;
    logic [6:0] sweep_h;
    logic       sweep_last;

    // The slot accepts whenever it is empty; out-of-range notes are acknowledged but dropped.
    assign draw_ack = draw_req && !slot_full && !reset;
    assign bad_note = draw_ack && (note > 4'(NOTES_PER_OCTAVE - 1));
    assign busy     = (state != IDLE);

    assign idx         = 6'(slot_octave) * 6'(NOTES_PER_OCTAVE) + 6'(slot_note);
    assign draw_y0     = 7'(Y_BASE) - {idx, 1'b0};
    assign draw_colour = {1'b0, slot_octave} + 3'd1;
    assign wrap        = ({1'b0, cursor} + 9'(COL_STEP)) > 9'(SCREEN_W - BOX_W);

    assign start_clear = (state == IDLE) && clear_pending;
    assign start_draw  = (state == IDLE) && !clear_pending && slot_full;
    assign sweep_start = start_clear || start_draw;
    assign sweep_x0    = start_clear ? 8'd0 : cursor;
    assign sweep_y0    = start_clear ? 7'd0 : draw_y0;
    assign sweep_w     = start_clear ? 8'(SCREEN_W) : 8'(BOX_W);
    assign sweep_h     = start_clear ? 7'(SCREEN_H) : 7'(BOX_H);

    pixel_sweeper u_sweeper (
        .clk    (clk),
        .reset  (reset),
        .start  (sweep_start),
        .x0     (sweep_x0),
        .y0     (sweep_y0),
        .w      (sweep_w),
        .h      (sweep_h),
        .x      (x),
        .y      (y),
        .active (writeEn),
        .last   (sweep_last)
    );

    // Clears win over queued notes, so a wrap always wipes the roll before the next block lands.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cursor        <= 8'(X_START);
            slot_full     <= 1'b0;
            slot_note     <= '0;
            slot_octave   <= '0;
            clear_pending <= 1'b0;
            colour        <= BLACK;
            done          <= 1'b0;
        end else begin
            done <= 1'b0;
            if (draw_ack && !bad_note) begin
                slot_full   <= 1'b1;
                slot_note   <= note;
                slot_octave <= octave;
            end
            if (clear_req) begin
                clear_pending <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start_clear) begin
                        state         <= CLEAR;
                        colour        <= BLACK;
                        clear_pending <= clear_req;
                    end else if (start_draw) begin
                        state     <= DRAW;
                        slot_full <= 1'b0;
                        colour    <= draw_colour;
                    end
                end
                CLEAR: begin
                    if (sweep_last) begin
                        cursor <= 8'(X_START);
                        done   <= 1'b1;
                        state  <= IDLE;
                    end
                end
                DRAW: begin
                    if (sweep_last) begin
                        done  <= 1'b1;
                        state <= IDLE;
                        if (wrap) begin
                            clear_pending <= 1'b1;
                        end else begin
                            cursor <= cursor + 8'(COL_STEP);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
